// File: rtl/div_sequencer_pkg.sv
// Shared divider definitions: bus width, iteration count, FSM encodings.
// Also used by the stall controller; DIV_ZERO_CHECK_EN selects the DZERO path.
package div_sequencer_pkg;

  localparam int DATA_BUS = 32;
  localparam int DIV_ITER = 32;
  localparam int CNT_W    = 5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DZERO = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_END   = 2'd3;

  typedef struct packed {
    logic [DATA_BUS-1:0] rem;
    logic [DATA_BUS-1:0] dvd;
  } div_pair_t;

  function automatic logic [DATA_BUS-1:0] neg_if(
    input logic                en,
    input logic [DATA_BUS-1:0] v
  );
    return en ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, dvd} left, trial-subtract.
// Purely combinational; the sequencer registers its outputs each cycle.
module div_step
  import div_sequencer_pkg::*;
(
  input  div_pair_t             i_pair,
  input  logic [DATA_BUS-1:0]   i_dvs,
  output logic [DATA_BUS-1:0]   o_rem,
  output logic [DATA_BUS-2:0]   o_dvd_shift,
  output logic                  o_qbit
);

  logic [DATA_BUS:0] w_trial;
  logic [DATA_BUS:0] w_diff;

  assign w_trial = {i_pair.rem, i_pair.dvd[DATA_BUS-1]};
  assign w_diff  = w_trial - {1'b0, i_dvs};

  // No borrow means the shifted remainder covers the divisor.
  assign o_qbit      = ~w_diff[DATA_BUS];
  assign o_rem       = o_qbit ? w_diff[DATA_BUS-1:0]
                              : w_trial[DATA_BUS-1:0];
  assign o_dvd_shift = i_pair.dvd[DATA_BUS-2:0];

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle 32-bit signed/unsigned restoring divider controller for EX.
// Optional DIV_ZERO_CHECK_EN adds a one-edge divide-by-zero fast path.
module div_sequencer
  import div_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                is_signed,
  input  logic [DATA_BUS-1:0] operand_1,
  input  logic [DATA_BUS-1:0] operand_2,
  input  logic                flush,
  output logic                busy,
  output logic                done,
  output logic [DATA_BUS-1:0] quotient,
  output logic [DATA_BUS-1:0] remainder
);

  logic [1:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  div_pair_t           r_pair;
  logic [DATA_BUS-1:0] r_dvs;
  logic                r_signed;
  logic                r_dvd_neg;
  logic                r_q_neg;
  logic                r_done;
  logic [DATA_BUS-1:0] r_quo;
  logic [DATA_BUS-1:0] r_rem;

  logic [DATA_BUS-1:0] w_op1_abs;
  logic [DATA_BUS-1:0] w_op2_abs;
  logic [DATA_BUS-1:0] w_rem;
  logic [DATA_BUS-2:0] w_shift;
  logic                w_qbit;
  logic                w_last;

  assign w_op1_abs = neg_if(is_signed & operand_1[DATA_BUS-1],
                            operand_1);
  assign w_op2_abs = neg_if(is_signed & operand_2[DATA_BUS-1],
                            operand_2);
  assign w_last    = (r_cnt == CNT_W'(DIV_ITER - 1));

  div_step u_step (
    .i_pair      (r_pair),
    .i_dvs       (r_dvs),
    .o_rem       (w_rem),
    .o_dvd_shift (w_shift),
    .o_qbit      (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pair    <= '0;
      r_dvs     <= '0;
      r_signed  <= 1'b0;
      r_dvd_neg <= 1'b0;
      r_q_neg   <= 1'b0;
      r_done    <= 1'b0;
      r_quo     <= '0;
      r_rem     <= '0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (start) begin
              r_signed  <= is_signed;
              r_dvd_neg <= operand_1[DATA_BUS-1];
              r_q_neg   <= operand_1[DATA_BUS-1]
                         ^ operand_2[DATA_BUS-1];
              r_cnt     <= '0;
              r_dvs     <= w_op2_abs;
`ifdef DIV_ZERO_CHECK_EN
              if (operand_2 == '0) begin
                r_state    <= S_DZERO;
                r_pair.rem <= '0;
                r_pair.dvd <= operand_1;
              end else begin
                r_state    <= S_RUN;
                r_pair.rem <= '0;
                r_pair.dvd <= w_op1_abs;
              end
`else
              r_state    <= S_RUN;
              r_pair.rem <= '0;
              r_pair.dvd <= w_op1_abs;
`endif
            end
          end
          S_RUN: begin
            r_pair.rem <= w_rem;
            r_pair.dvd <= {w_shift, w_qbit};
            r_cnt      <= r_cnt + 1'b1;
            if (w_last) begin
              r_state <= S_END;
            end
          end
          S_END: begin
            r_quo   <= neg_if(r_signed & r_q_neg, r_pair.dvd);
            r_rem   <= neg_if(r_signed & r_dvd_neg, r_pair.rem);
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
          S_DZERO: begin
`ifdef DIV_ZERO_CHECK_EN
            r_quo  <= '1;
            r_rem  <= r_pair.dvd;
            r_done <= 1'b1;
`endif
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign quotient  = r_quo;
  assign remainder = r_rem;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: directed divisions, flush, reset,
// divide-by-zero (both builds) and back-to-back starts.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;
  logic        prev_done = 1'b0;
  int          dz_lat;

  always #5 clk = ~clk;

  div_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever done is presented.
  always @(posedge clk) begin
    #1;
    if (done) begin
      check("done_single", {31'b0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got q=%h r=%h expected none",
                 quotient, remainder);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_q"}, quotient, mon_e.q);
        check({mon_e.name, "_r"}, remainder, mon_e.r);
      end
    end
    prev_done = done;
  end

  task automatic run_div(input string name,
                         input logic sgn,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] eq,
                         input logic [31:0] er,
                         input int lat);
    int   edges;
    exp_t e;
    @(negedge clk);
    start     = 1'b1;
    is_signed = sgn;
    operand_1 = a;
    operand_2 = b;
    e.q = eq;
    e.r = er;
    e.name = name;
    sb.push_back(e);
    last_q = eq;
    last_r = er;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({name, "_busy"}, {31'b0, busy}, 32'd1);
    edges = 0;
    while (!done && edges < 60) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({name, "_lat"}, 32'(edges), 32'(lat));
    check({name, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
`ifdef DIV_ZERO_CHECK_EN
    dz_lat = 1;
`else
    dz_lat = 33;
`endif
    rst = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    operand_1 = '0;
    operand_2 = '0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7,
            32'd14, 32'd2, 33);
    run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2,
            32'hFFFFFFFD, 32'hFFFFFFFF, 33);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE,
            32'hFFFFFFFD, 32'd1, 33);
    run_div("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF,
            32'h80000000, 32'd0, 33);
    run_div("divu_max_16", 1'b0, 32'hFFFFFFFF, 32'd16,
            32'h0FFFFFFF, 32'd15, 33);
    run_div("div_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,
            32'd14, 32'hFFFFFFFE, 33);
    run_div("divu_3_5", 1'b0, 32'd3, 32'd5,
            32'd0, 32'd3, 33);
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0,
            32'hFFFFFFFF, 32'd5, dz_lat);
`ifdef DIV_ZERO_CHECK_EN
    run_div("div_m5_0", 1'b1, 32'hFFFFFFFB, 32'd0,
            32'hFFFFFFFF, 32'hFFFFFFFB, dz_lat);
`else
    run_div("div_m5_0", 1'b1, 32'hFFFFFFFB, 32'd0,
            32'd1, 32'hFFFFFFFB, dz_lat);
`endif

    // Flush on E10 with an ignored start on E5.
    @(negedge clk);
    start = 1'b1;
    is_signed = 1'b0;
    operand_1 = 32'd100;
    operand_2 = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = (k == 5);
      flush = (k == 10);
      if (k == 5) begin
        operand_1 = 32'd1;
        operand_2 = 32'd1;
      end
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_done", {31'b0, done}, 32'd0);
    check("flush_q", quotient, last_q);
    check("flush_r", remainder, last_r);
    repeat (3) @(posedge clk);
    #1;
    check("flush_stay_idle", {31'b0, busy}, 32'd0);
    run_div("divu_9_4", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 33);

    // Reset on E20 of a run.
    @(negedge clk);
    start = 1'b1;
    is_signed = 1'b0;
    operand_1 = 32'd100;
    operand_2 = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst20_busy", {31'b0, busy}, 32'd0);
    check("rst20_done", {31'b0, done}, 32'd0);
    check("rst20_q", quotient, 32'd0);
    check("rst20_r", remainder, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back: second start lands in the first done cycle.
    run_div("b2b_a", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    run_div("b2b_b", 1'b1, 32'hFFFFFF9C, 32'd7,
            32'hFFFFFFF2, 32'hFFFFFFFE, 33);

    repeat (4) @(posedge clk);
    #2;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
